// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: sequential PC, one outstanding imem read, DEPTH-entry {pc,instr,adel} buffer.
// Optional IFETCH_BYPASS_EN forwards a returning word straight to decode when the buffer is empty.
//
// state   | meaning
// REQ     | request may be issued at pc (or adel marker pushed if pc misaligned)
// WAIT    | one read outstanding, one buffer slot implicitly reserved
// DISCARD | outstanding read was squashed by a redirect; its data is dropped
// HALT    | adel marker pushed; only a redirect restarts fetch
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_adel,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {REQ, WAIT, DISCARD, HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic          run;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic          fifo_adel  [DEPTH];

    logic          head_valid;
    logic          bypass;
    logic          handshake;
    logic          push_en;
    logic          pop_en;
    logic [31:0]   push_pc;
    logic [31:0]   push_instr;
    logic          push_adel;
    logic [31:0]   pc_prev;

    assign pc_prev    = pc - 32'd4;
    assign head_valid = (count != '0);
    assign inst_req   = run && (state == REQ) && (count < DEPTH_C) && (pc[1:0] == 2'b00);
    assign inst_addr  = pc;
    assign handshake  = inst_req && inst_addr_ok;

`ifdef IFETCH_BYPASS_EN
    assign bypass = !head_valid && (state == WAIT) && inst_data_ok && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = head_valid || bypass;
    assign instr       = head_valid ? fifo_instr[rd_ptr] : (bypass ? inst_rdata : 32'h0);
    assign instr_pc    = head_valid ? fifo_pc[rd_ptr]    : (bypass ? pc_prev    : 32'h0);
    assign instr_adel  = head_valid && fifo_adel[rd_ptr];

    always_comb begin
        push_en    = 1'b0;
        push_pc    = pc_prev;
        push_instr = inst_rdata;
        push_adel  = 1'b0;
        pop_en     = head_valid && instr_ready && !redirect_valid;
        if (!redirect_valid) begin
            case (state)
                WAIT: begin
                    if (inst_data_ok) push_en = !(bypass && instr_ready);
                end
                REQ: begin
                    if (run && (pc[1:0] != 2'b00) && (count < DEPTH_C)) begin
                        push_en    = 1'b1;
                        push_pc    = pc;
                        push_instr = 32'h0;
                        push_adel  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= REQ;
            pc     <= RESET_PC;
            run    <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                pc     <= redirect_pc;
                case (state)
                    REQ:     state <= handshake ? DISCARD : REQ;
                    WAIT:    state <= inst_data_ok ? REQ : DISCARD;
                    DISCARD: state <= inst_data_ok ? REQ : DISCARD;
                    default: state <= REQ;
                endcase
            end else begin
                if (push_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
                case ({push_en, pop_en})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                case (state)
                    REQ: begin
                        if (handshake) begin
                            state <= WAIT;
                            pc    <= pc + 32'd4;
                        end else if (push_en) begin
                            state <= HALT;
                        end
                    end
                    WAIT:    if (inst_data_ok) state <= REQ;
                    DISCARD: if (inst_data_ok) state <= REQ;
                    default: state <= HALT;
                endcase
            end
        end
    end

    // buffer payload needs no reset: outputs are masked while count is zero
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
            fifo_adel[wr_ptr]  <= push_adel;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit (default build, no bypass); scoreboard queue of expected buffer entries.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_adel;
    logic        instr_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        adel;
    } ent_t;

    ent_t q[$];
    int   ncmp = 0;
    int   nerr = 0;

    inst_fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_adel     (instr_adel),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] addr, input string tag);
        int n = 0;
        while (inst_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_req"}, {31'b0, inst_req}, 32'd1);
        chk({tag, "_addr"}, inst_addr, addr);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] w, input string tag);
        ent_t e;
        wait_req(addr, tag);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        chk({tag, "_wait_noreq"}, {31'b0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = w;
        e.pc = addr; e.ins = w; e.adel = 1'b0;
        q.push_back(e);
        step();
        inst_data_ok = 1'b0;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int   t = 0;
            ent_t e;
            e.pc = 32'h0; e.ins = 32'h0; e.adel = 1'b0;
            if (q.size() > 0) e = q.pop_front();
            while (instr_valid !== 1'b1 && t < 50) begin
                step();
                t++;
            end
            chk({tag, "_hv"}, {31'b0, instr_valid}, 32'd1);
            chk({tag, "_instr"}, instr, e.ins);
            chk({tag, "_pc"}, instr_pc, e.pc);
            chk({tag, "_adel"}, {31'b0, instr_adel}, {31'b0, e.adel});
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end
    endtask

    initial begin
        ent_t e;
        resetn = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

        // reset values
        step(); step();
        chk("rst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_addr", inst_addr, 32'hBFC0_0000);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_adel", {31'b0, instr_adel}, 32'd0);
        resetn = 1'b1;
        step();
        chk("first_req", {31'b0, inst_req}, 32'd1);

        // first fetch, latency and back-to-back request
        fetch(32'hBFC0_0000, 32'h2408_0001, "f0");
        chk("b2b_req", {31'b0, inst_req}, 32'd1);
        chk("b2b_addr", inst_addr, 32'hBFC0_0004);
        drain(1, "f0");

        // fill the buffer with decode stalled
        resetn = 1'b0; step(); resetn = 1'b1; step();
        for (int i = 0; i < 4; i++)
            fetch(32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), "fill");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_noreq", {31'b0, inst_req}, 32'd0);
        end
        drain(1, "full_pop");
        chk("after_pop_req", {31'b0, inst_req}, 32'd1);
        chk("after_pop_addr", inst_addr, 32'hBFC0_0010);
        fetch(32'hBFC0_0010, 32'h1000_0004, "fill5");
        drain(4, "fill_drain");

        // redirect while read outstanding -> discard
        wait_req(32'hBFC0_0014, "sq");
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        chk("disc_noreq", {31'b0, inst_req}, 32'd0);
        chk("disc_valid", {31'b0, instr_valid}, 32'd0);
        step(); step();
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        step();
        inst_data_ok = 1'b0;
        chk("disc_drop", {31'b0, instr_valid}, 32'd0);
        chk("disc_req", {31'b0, inst_req}, 32'd1);
        chk("disc_addr", inst_addr, 32'h8000_0100);

        // redirect coincident with data return and pop
        fetch(32'h8000_0100, 32'h0000_0AAA, "co0");
        wait_req(32'h8000_0104, "co1");
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h0000_0BBB; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        q.delete();
        step();
        inst_data_ok = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        chk("co_valid", {31'b0, instr_valid}, 32'd0);
        chk("co_req", {31'b0, inst_req}, 32'd1);
        chk("co_addr", inst_addr, 32'h8000_0200);
        step();
        chk("co_still_empty", {31'b0, instr_valid}, 32'd0);

        // misaligned redirect -> adel marker, halt
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        e.pc = 32'h8000_0102; e.ins = 32'h0; e.adel = 1'b1;
        q.push_back(e);
        step();
        redirect_valid = 1'b0;
        chk("mis_noreq", {31'b0, inst_req}, 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("halt_noreq", {31'b0, inst_req}, 32'd0);
            step();
        end
        drain(1, "adel");
        step();
        chk("halt_noreq2", {31'b0, inst_req}, 32'd0);
        chk("halt_empty", {31'b0, instr_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0380;
        step();
        redirect_valid = 1'b0;
        chk("unhalt_req", {31'b0, inst_req}, 32'd1);
        chk("unhalt_addr", inst_addr, 32'hBFC0_0380);

        // reset while WAIT, stale data after release
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        resetn = 1'b0;
        step();
        chk("mid_rst_req", {31'b0, inst_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        resetn = 1'b1;
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_AAAA;
        step();
        inst_data_ok = 1'b0;
        chk("stale_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'hBFC0_0000, 32'h2408_0002, "post_rst");
        drain(1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
